// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file and trap controller for an RV32 core.
// Serves Zicsr reads/writes, tracks 64-bit mcycle/minstret, samples interrupt
// lines into mip, and arbitrates exceptions, interrupts and mret into a
// single-cycle redirect for fetch.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   csr_valid/op/addr/src/src_zero Zicsr request from decode/execute
//   csr_rdata, csr_illegal        old CSR value and access fault (comb)
//   exc_valid/code/tval, cur_pc   synchronous exception from the pipeline
//   int_window, mret, instr_retire pipeline status
//   irq_sw/timer/ext, irq_local   level-sensitive interrupt lines
//   redirect, redirect_pc         fetch redirect (comb)
//   irq_pending                   (mip & mie) != 0
module csr_trap_unit #(
  parameter int          NUM_LOCAL   = 4,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_1101,
  parameter int          HART_ID     = 0,
  parameter bit          COUNTERS_EN = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   csr_valid,
  input  logic [2:0]                             csr_op,
  input  logic [11:0]                            csr_addr,
  input  logic [31:0]                            csr_src,
  input  logic                                   csr_src_zero,
  output logic [31:0]                            csr_rdata,
  output logic                                   csr_illegal,
  input  logic                                   exc_valid,
  input  logic [4:0]                             exc_code,
  input  logic [31:0]                            exc_tval,
  input  logic [31:0]                            cur_pc,
  input  logic                                   int_window,
  input  logic                                   mret,
  input  logic                                   instr_retire,
  input  logic                                   irq_sw,
  input  logic                                   irq_timer,
  input  logic                                   irq_ext,
  input  logic [(NUM_LOCAL > 0 ? NUM_LOCAL : 1)-1:0] irq_local,
  output logic                                   redirect,
  output logic [31:0]                            redirect_pc,
  output logic                                   irq_pending
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;
  localparam logic [11:0] A_MIMPID    = 12'hF13;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  // Implemented interrupt bits: MSI, MTI, MEI and the local lines at 16+.
  localparam logic [31:0] LOCAL_MASK = (NUM_LOCAL == 0) ? 32'h0 :
                                       (((32'h1 << NUM_LOCAL) - 32'h1) << 16);
  localparam logic [31:0] IRQ_MASK   = 32'h0000_0888 | LOCAL_MASK;

  // State
  logic        st_mie, st_mpie;
  logic [31:0] mie_q, mip_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0] mcycle_q, minstret_q;

  // Combinational
  logic [31:0] mip_next, pend, rdata, wdata;
  logic [4:0]  irq_code, trap_code;
  logic        impl, op_ok, wr_req, ro_addr, csr_we;
  logic        take_exc, take_irq, trap;
  logic [31:0] vec_base;

  always_comb begin
    mip_next     = '0;
    mip_next[3]  = irq_sw;
    mip_next[7]  = irq_timer;
    mip_next[11] = irq_ext;
    for (int i = 0; i < NUM_LOCAL; i++) mip_next[16+i] = irq_local[i];
  end

  assign pend        = mip_q & mie_q;
  assign irq_pending = |pend;

  // Fixed priority: MEI > MSI > MTI > local 0 > local 1 ...
  // Written lowest-first so the highest-priority assignment lands last.
  always_comb begin
    irq_code = 5'd0;
    for (int i = NUM_LOCAL - 1; i >= 0; i--)
      if (pend[16+i]) irq_code = 5'(16 + i);
    if (pend[7])  irq_code = 5'd7;
    if (pend[3])  irq_code = 5'd3;
    if (pend[11]) irq_code = 5'd11;
  end

  assign take_exc  = exc_valid;
  assign take_irq  = !exc_valid && int_window && st_mie && (|pend);
  assign trap      = take_exc || take_irq;
  assign trap_code = take_exc ? exc_code : irq_code;

  // CSR read mux
  always_comb begin
    rdata = '0;
    impl  = 1'b1;
    case (csr_addr)
      A_MSTATUS:   rdata = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
      A_MISA:      rdata = MISA_VALUE;
      A_MIE:       rdata = mie_q;
      A_MTVEC:     rdata = mtvec_q;
      A_MSCRATCH:  rdata = mscratch_q;
      A_MEPC:      rdata = mepc_q;
      A_MCAUSE:    rdata = mcause_q;
      A_MTVAL:     rdata = mtval_q;
      A_MIP:       rdata = mip_q;
      A_MCYCLE:    rdata = COUNTERS_EN ? mcycle_q[31:0]   : 32'h0;
      A_MCYCLEH:   rdata = COUNTERS_EN ? mcycle_q[63:32]  : 32'h0;
      A_MINSTRET:  rdata = COUNTERS_EN ? minstret_q[31:0] : 32'h0;
      A_MINSTRETH: rdata = COUNTERS_EN ? minstret_q[63:32] : 32'h0;
      A_MVENDORID: rdata = 32'h0;
      A_MARCHID:   rdata = 32'h0;
      A_MIMPID:    rdata = 32'h0;
      A_MHARTID:   rdata = 32'(HART_ID);
      default:     impl  = 1'b0;
    endcase
  end

  assign csr_rdata = rdata;

  always_comb begin
    case (csr_op[1:0])
      2'b01:   wdata = csr_src;
      2'b10:   wdata = rdata | csr_src;
      2'b11:   wdata = rdata & ~csr_src;
      default: wdata = rdata;
    endcase
  end

  assign op_ok   = csr_op inside {3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
  // Set/clear forms with a zero source are pure reads.
  assign wr_req  = csr_valid && op_ok && ((csr_op[1:0] == 2'b01) || !csr_src_zero);
  assign ro_addr = (csr_addr[11:10] == 2'b11) || (csr_addr == A_MISA);
  assign csr_illegal = csr_valid && (!impl || (wr_req && ro_addr));
  // A trap or mret in the same cycle drops the CSR write.
  assign csr_we  = wr_req && !csr_illegal && !trap && !mret;

  assign vec_base = {mtvec_q[31:2], 2'b00};

  always_comb begin
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    if (!rst) begin
      redirect = trap || mret;
      if (trap)
        redirect_pc = (take_irq && mtvec_q[1:0] == 2'b01) ?
                      vec_base + {25'b0, irq_code, 2'b00} : vec_base;
      else
        redirect_pc = mepc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_q      <= '0;
      mip_q      <= '0;
      mtvec_q    <= RESET_MTVEC;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mip_q <= mip_next;

      // Counters: a write to either half replaces it and skips the increment.
      if (COUNTERS_EN) begin
        if (csr_we && csr_addr == A_MCYCLE)       mcycle_q[31:0]  <= wdata;
        else if (csr_we && csr_addr == A_MCYCLEH) mcycle_q[63:32] <= wdata;
        else                                      mcycle_q <= mcycle_q + 64'd1;

        if (csr_we && csr_addr == A_MINSTRET)       minstret_q[31:0]  <= wdata;
        else if (csr_we && csr_addr == A_MINSTRETH) minstret_q[63:32] <= wdata;
        else if (instr_retire)                      minstret_q <= minstret_q + 64'd1;
      end

      if (trap) begin
        mepc_q   <= cur_pc & ~32'h3;
        mcause_q <= {take_irq, 26'b0, trap_code};
        mtval_q  <= take_exc ? exc_tval : 32'h0;
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
      end else if (mret) begin
        st_mie   <= st_mpie;
        st_mpie  <= 1'b1;
      end else if (csr_we) begin
        case (csr_addr)
          A_MSTATUS: begin
            st_mie  <= wdata[3];
            st_mpie <= wdata[7];
          end
          A_MIE:      mie_q      <= wdata & IRQ_MASK;
          // MODE 2/3 are reserved; fall back to direct mode.
          A_MTVEC:    mtvec_q    <= wdata[1] ? {wdata[31:2], 2'b00} : wdata;
          A_MSCRATCH: mscratch_q <= wdata;
          A_MEPC:     mepc_q     <= wdata & ~32'h3;
          A_MCAUSE:   mcause_q   <= wdata;
          A_MTVAL:    mtval_q    <= wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
module tb_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_valid, csr_src_zero;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_src, csr_rdata;
  logic        csr_illegal;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_tval, cur_pc;
  logic        int_window, mret, instr_retire;
  logic        irq_sw, irq_timer, irq_ext;
  logic [3:0]  irq_local;
  logic        redirect, irq_pending;
  logic [31:0] redirect_pc;

  csr_trap_unit dut (
    .clk(clk), .rst(rst),
    .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_src(csr_src), .csr_src_zero(csr_src_zero),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_tval(exc_tval),
    .cur_pc(cur_pc), .int_window(int_window), .mret(mret),
    .instr_retire(instr_retire),
    .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext),
    .irq_local(irq_local),
    .redirect(redirect), .redirect_pc(redirect_pc), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clr();
    csr_valid = 0; csr_op = 0; csr_addr = 0; csr_src = 0; csr_src_zero = 0;
    exc_valid = 0; exc_code = 0; exc_tval = 0; cur_pc = 0;
    int_window = 0; mret = 0; instr_retire = 0;
    irq_sw = 0; irq_timer = 0; irq_ext = 0; irq_local = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; clr(); step(); step(); rst = 0;
  endtask

  // Pure read (CSRRS with x0); no clock edge consumed.
  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    csr_valid = 1; csr_op = 3'b010; csr_addr = a; csr_src = 0; csr_src_zero = 1;
    #1 v = csr_rdata;
    csr_valid = 0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_valid = 1; csr_op = 3'b001; csr_addr = a; csr_src = d; csr_src_zero = (d == 0);
    step();
    csr_valid = 0;
  endtask

  // ---------------- reference model ----------------
  logic        m_mie_b, m_mpie;
  logic [31:0] m_mie, m_mip, m_mtvec, m_scr, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cyc, m_ins;
  localparam logic [31:0] M_IRQ_MASK = 32'h000F_0888;
  int prio [7] = '{11, 3, 7, 16, 17, 18, 19};

  function automatic bit m_read(input logic [11:0] a, output logic [31:0] v);
    v = 0; m_read = 1;
    case (a)
      12'h300: v = 32'h1800 | (m_mie_b ? 32'h8 : 0) | (m_mpie ? 32'h80 : 0);
      12'h301: v = 32'h4000_1101;
      12'h304: v = m_mie;
      12'h305: v = m_mtvec;
      12'h340: v = m_scr;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = m_mip;
      12'hB00: v = m_cyc[31:0];
      12'hB80: v = m_cyc[63:32];
      12'hB02: v = m_ins[31:0];
      12'hB82: v = m_ins[63:32];
      12'hF11, 12'hF12, 12'hF13, 12'hF14: v = 0;
      default: m_read = 0;
    endcase
  endfunction

  task automatic random_run(input int n);
    logic [11:0] addrs [15] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                12'h343, 12'h344, 12'h301, 12'hB00, 12'hB80, 12'hB02,
                                12'hB82, 12'hF14, 12'h7C0};
    logic [2:0]  ops [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    logic [31:0] old, nv, base, epc;
    logic [63:0] n_cyc, n_ins;
    bit impl, wreq, ill, irq_take, trap, is_irq, we;
    int code;
    do_reset();
    m_mie_b = 0; m_mpie = 0; m_mie = 0; m_mip = 0; m_mtvec = 0; m_scr = 0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cyc = 0; m_ins = 0;
    for (int k = 0; k < n; k++) begin
      csr_valid    = ($urandom_range(0, 9) < 6);
      csr_op       = ops[$urandom_range(0, 5)];
      csr_addr     = addrs[$urandom_range(0, 14)];
      csr_src      = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      csr_src_zero = (csr_src == 0);
      exc_valid    = ($urandom_range(0, 9) == 0);
      exc_code     = 5'($urandom_range(0, 15));
      exc_tval     = $urandom;
      cur_pc       = $urandom & ~32'h3;
      int_window   = $urandom_range(0, 1);
      mret         = ($urandom_range(0, 9) == 0);
      instr_retire = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) irq_sw    = ~irq_sw;
      if ($urandom_range(0, 7) == 0) irq_timer = ~irq_timer;
      if ($urandom_range(0, 7) == 0) irq_ext   = ~irq_ext;
      if ($urandom_range(0, 7) == 0) irq_local = 4'($urandom);
      #2;
      // expected outputs from the spec rules
      impl = m_read(csr_addr, old);
      wreq = csr_valid && (csr_op == 3'b001 || csr_op == 3'b101 || !csr_src_zero);
      ill  = csr_valid && (!impl || (wreq && (csr_addr[11:10] == 2'b11 || csr_addr == 12'h301)));
      code = 0; irq_take = 0;
      foreach (prio[j]) if (!irq_take && m_mip[prio[j]] && m_mie[prio[j]]) begin
        irq_take = 1; code = prio[j];
      end
      chk("rnd_irq_pending", 32'(irq_pending), 32'((m_mip & m_mie) != 0));
      irq_take = irq_take && int_window && m_mie_b;
      trap   = exc_valid || irq_take;
      is_irq = !exc_valid && irq_take;
      base   = m_mtvec & ~32'h3;
      epc    = (is_irq && m_mtvec[1:0] == 2'b01) ? base + 32'(4 * code) : base;
      chk("rnd_redirect", 32'(redirect), 32'(trap || mret));
      if (trap)      chk("rnd_trap_pc", redirect_pc, epc);
      else if (mret) chk("rnd_mret_pc", redirect_pc, m_mepc);
      chk("rnd_illegal", 32'(csr_illegal), 32'(ill));
      if (csr_valid && impl) chk("rnd_rdata", csr_rdata, old);
      // next state
      case (csr_op[1:0])
        2'b01:   nv = csr_src;
        2'b10:   nv = old | csr_src;
        default: nv = old & ~csr_src;
      endcase
      we    = wreq && !ill && !trap && !mret;
      n_cyc = m_cyc + 1;
      n_ins = m_ins + 64'(instr_retire);
      if (trap) begin
        m_mepc   = cur_pc;
        m_mcause = is_irq ? (32'h8000_0000 | 32'(code)) : 32'(exc_code);
        m_mtval  = is_irq ? 0 : exc_tval;
        m_mpie   = m_mie_b;
        m_mie_b  = 0;
      end else if (mret) begin
        m_mie_b = m_mpie;
        m_mpie  = 1;
      end else if (we) begin
        case (csr_addr)
          12'h300: begin m_mie_b = nv[3]; m_mpie = nv[7]; end
          12'h304: m_mie    = nv & M_IRQ_MASK;
          12'h305: m_mtvec  = (nv[1:0] >= 2) ? (nv & ~32'h3) : nv;
          12'h340: m_scr    = nv;
          12'h341: m_mepc   = nv & ~32'h3;
          12'h342: m_mcause = nv;
          12'h343: m_mtval  = nv;
          12'hB00: n_cyc = {m_cyc[63:32], nv};
          12'hB80: n_cyc = {nv, m_cyc[31:0]};
          12'hB02: n_ins = {m_ins[63:32], nv};
          12'hB82: n_ins = {nv, m_ins[31:0]};
          default: ;
        endcase
      end
      m_cyc = n_cyc;
      m_ins = n_ins;
      m_mip = 0;
      m_mip[3] = irq_sw; m_mip[7] = irq_timer; m_mip[11] = irq_ext;
      for (int j = 0; j < 4; j++) m_mip[16+j] = irq_local[j];
      step();
    end
    clr();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        ill;
  } vec_t;
  vec_t tbl [14];

  initial begin
    logic [31:0] v;
    tbl[0]  = '{12'h340, 32'h1234_5678, 32'h1234_5678, 1'b0};
    tbl[1]  = '{12'h341, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0};
    tbl[2]  = '{12'h305, 32'h0000_2002, 32'h0000_2000, 1'b0};
    tbl[3]  = '{12'h305, 32'h0000_2003, 32'h0000_2000, 1'b0};
    tbl[4]  = '{12'h305, 32'h0000_3001, 32'h0000_3001, 1'b0};
    tbl[5]  = '{12'h300, 32'hFFFF_FFFF, 32'h0000_1888, 1'b0};
    tbl[6]  = '{12'h300, 32'h0000_0000, 32'h0000_1800, 1'b0};
    tbl[7]  = '{12'h304, 32'hFFFF_FFFF, 32'h000F_0888, 1'b0};
    tbl[8]  = '{12'h342, 32'h8000_000B, 32'h8000_000B, 1'b0};
    tbl[9]  = '{12'h343, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
    tbl[10] = '{12'h301, 32'h0000_0000, 32'h4000_1101, 1'b1};
    tbl[11] = '{12'hF14, 32'h0000_0005, 32'h0000_0000, 1'b1};
    tbl[12] = '{12'hF11, 32'h0000_0007, 32'h0000_0000, 1'b1};
    tbl[13] = '{12'h344, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};

    rst = 1; clr();
    step();
    // reset state, sampled while reset is still held
    chk("rst_redirect", 32'(redirect), 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_irq_pending", 32'(irq_pending), 0);
    rd(12'h300, v); chk("rst_mstatus", v, 32'h1800);
    rd(12'h305, v); chk("rst_mtvec", v, 32'h0);
    rd(12'hB00, v); chk("rst_mcycle", v, 32'h0);
    rst = 0;

    // 1: mscratch RW then RS
    wr(12'h340, 32'hDEAD_BEEF);
    csr_valid = 1; csr_op = 3'b010; csr_addr = 12'h340; csr_src = 32'hF; csr_src_zero = 0;
    #1 chk("t1_rs_rdata", csr_rdata, 32'hDEAD_BEEF);
    step(); csr_valid = 0;
    rd(12'h340, v); chk("t1_mscratch", v, 32'hDEAD_BEEF);

    // 2: vectored external interrupt
    wr(12'h305, 32'h1001); wr(12'h300, 32'h8); wr(12'h304, 32'h800);
    irq_ext = 1; int_window = 1; cur_pc = 32'h400;
    #1 chk("t2_no_redirect_yet", 32'(redirect), 0);
    chk("t2_no_pending_yet", 32'(irq_pending), 0);
    step();
    chk("t2_redirect", 32'(redirect), 1);
    chk("t2_redirect_pc", redirect_pc, 32'h102C);
    chk("t2_pending", 32'(irq_pending), 1);
    step(); clr();
    chk("t2_no_retrap", 32'(redirect), 0);
    rd(12'h342, v); chk("t2_mcause", v, 32'h8000_000B);
    rd(12'h300, v); chk("t2_mstatus", v, 32'h1880);
    rd(12'h341, v); chk("t2_mepc", v, 32'h400);
    rd(12'h343, v); chk("t2_mtval", v, 32'h0);

    // 3: exception beats mret, direct base even though MODE=1
    exc_valid = 1; exc_code = 5'd2; exc_tval = 32'h55; mret = 1; cur_pc = 32'h200;
    #1 chk("t3_redirect", 32'(redirect), 1);
    chk("t3_redirect_pc", redirect_pc, 32'h1000);
    step(); clr();
    rd(12'h341, v); chk("t3_mepc", v, 32'h200);
    rd(12'h342, v); chk("t3_mcause", v, 32'h2);
    rd(12'h300, v); chk("t3_mstatus", v, 32'h1800);
    rd(12'h343, v); chk("t3_mtval", v, 32'h55);

    // 4: mcycle carry into high half, write suppresses increment
    wr(12'hB80, 32'h0);
    wr(12'hB00, 32'hFFFF_FFFF);
    rd(12'hB00, v); chk("t4_lo_written", v, 32'hFFFF_FFFF);
    rd(12'hB80, v); chk("t4_hi_written", v, 32'h0);
    step();
    rd(12'hB00, v); chk("t4_lo_wrap", v, 32'h0);
    rd(12'hB80, v); chk("t4_hi_carry", v, 32'h1);
    wr(12'hB00, 32'h5);
    rd(12'hB00, v); chk("t4_lo_no_inc", v, 32'h5);

    // 5: table of writes, WARL and illegal accesses
    for (int i = 0; i < 14; i++) begin
      csr_valid = 1; csr_op = 3'b001; csr_addr = tbl[i].addr;
      csr_src = tbl[i].wdata; csr_src_zero = (tbl[i].wdata == 0);
      #1 chk($sformatf("tbl%0d_illegal", i), 32'(csr_illegal), 32'(tbl[i].ill));
      step(); csr_valid = 0;
      rd(tbl[i].addr, v); chk($sformatf("tbl%0d_read", i), v, tbl[i].exp);
    end
    csr_valid = 1; csr_op = 3'b010; csr_addr = 12'h7C0; csr_src_zero = 1;
    #1 chk("t5_unimpl_illegal", 32'(csr_illegal), 1);
    csr_valid = 0;

    // 6: trap, mret, then reset in the middle of a trap
    do_reset();
    wr(12'h305, 32'h100); wr(12'h300, 32'h8);
    exc_valid = 1; exc_code = 5'd3; cur_pc = 32'h80;
    #1 chk("t6_trap_pc", redirect_pc, 32'h100);
    step(); clr();
    rd(12'h300, v); chk("t6_mstatus_trap", v, 32'h1880);
    mret = 1;
    #1 chk("t6_mret_redirect", 32'(redirect), 1);
    chk("t6_mret_pc", redirect_pc, 32'h80);
    step(); clr();
    rd(12'h300, v); chk("t6_mstatus_mret", v, 32'h1888);
    exc_valid = 1; cur_pc = 32'h300;
    #1 chk("t6_pre_rst_redirect", 32'(redirect), 1);
    rst = 1;
    #1 chk("t6_rst_redirect", 32'(redirect), 0);
    chk("t6_rst_redirect_pc", redirect_pc, 0);
    rd(12'h300, v); chk("t6_rst_mstatus", v, 32'h1800);
    step(); rst = 0; clr();
    #1 chk("t6_post_redirect", 32'(redirect), 0);
    rd(12'h341, v); chk("t6_post_mepc", v, 32'h0);
    rd(12'h300, v); chk("t6_post_mstatus", v, 32'h1800);

    // randomized run against the model
    random_run(600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
